// File: rtl/prog_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_pkg
//  Description : Shared definitions for the loadable program memory:
//                instruction width and fetch/load state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_pkg;

    // Instruction word: opcode plus register field
    localparam int INSTRUCTION_WIDTH = 6;

    // Block operating mode; one bit is enough for the two modes
    typedef enum logic [0:0] {
        PM_S_RUN  = 1'b0,
        PM_S_LOAD = 1'b1
    } pm_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_array
//  Description : DEPTH x INSTR_W storage, one synchronous write port and one
//                synchronous read port. No reset: contents survive rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_array #(
    parameter int INSTR_W = 6,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdata;

    // Write port: callers guarantee waddr < DEPTH whenever we is high
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port: output register only updates on an enabled read, so it holds
    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem
//  Description : Loadable instruction memory with a one-cycle registered
//                fetch port, LOAD/RUN mode control, range checking and error
//                reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int                 INSTR_W  = INSTRUCTION_WIDTH,
    parameter int                 ADDR_W   = 5,
    parameter int                 DEPTH    = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_data,
    output logic               fetch_err,
    output logic               in_load,
    output logic [ADDR_W:0]    load_count
);

    // DEPTH in the same (ADDR_W+1)-bit unsigned domain as the address compares
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    pm_state_t          r_state;
    pm_state_t          w_state_next;
    logic               w_fetch_in_range;
    logic               w_load_in_range;
    logic               w_rd_en;
    logic               w_wr_en;
    logic               w_enter_load;
    logic [INSTR_W-1:0] w_rd_data;
    logic               r_fetch_valid;
    logic               r_fetch_err;
    logic               r_rsp_nop;
    logic               r_in_load;
    logic [ADDR_W:0]    r_load_count;

    assign w_fetch_in_range = ({1'b0, fetch_addr} < c_depth);
    assign w_load_in_range  = ({1'b0, load_addr}  < c_depth);

    // Good reads only in RUN, writes only in LOAD: the two never collide
    assign w_rd_en      = fetch_req && (r_state == PM_S_RUN)  && w_fetch_in_range;
    assign w_wr_en      = load_we   && (r_state == PM_S_LOAD) && w_load_in_range;
    assign w_enter_load = (r_state == PM_S_RUN) && (w_state_next == PM_S_LOAD);

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PM_S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mode transitions follow the prog_mode level
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PM_S_RUN:  if (prog_mode)  w_state_next = PM_S_LOAD;
            PM_S_LOAD: if (!prog_mode) w_state_next = PM_S_RUN;
            default:   w_state_next = PM_S_RUN;
        endcase
    end

    // in_load mirrors the state register; load_count restarts on LOAD entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_load    <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_in_load <= (w_state_next == PM_S_LOAD);
            if (w_enter_load) begin
                r_load_count <= '0;
            end else if (w_wr_en && (r_load_count != c_depth)) begin
                r_load_count <= r_load_count + 1'b1;
            end
        end
    end

    // Fetch response: r_rsp_nop remembers whether the last response was an
    // error so fetch_data keeps showing NOP until the next response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_rsp_nop     <= 1'b1;
        end else begin
            r_fetch_valid <= fetch_req;
            if (fetch_req) begin
                r_fetch_err <= !w_rd_en;
                r_rsp_nop   <= !w_rd_en;
            end else begin
                r_fetch_err <= 1'b0;
            end
        end
    end

    prog_mem_array #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (w_rd_en),
        .raddr (fetch_addr),
        .rdata (w_rd_data)
    );

    assign fetch_valid = r_fetch_valid;
    assign fetch_err   = r_fetch_err;
    assign fetch_data  = r_rsp_nop ? NOP_WORD : w_rd_data;
    assign in_load     = r_in_load;
    assign load_count  = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_mem
//  Description : Self-checking bench for prog_mem. Drives a full-depth
//                (DEPTH=32) and a partial-depth (DEPTH=20) instance with the
//                same stimulus and compares both against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem;

    localparam int AW = 5;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_mode;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;

    logic          v32, e32, il32, v20, e20, il20;
    logic [IW-1:0] d32, d20;
    logic [AW:0]   lc32, lc20;

    always #5 clk = ~clk;

    prog_mem #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(32)) dut32 (
        .clk(clk), .rst(rst), .prog_mode(prog_mode), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_valid(v32), .fetch_data(d32),
        .fetch_err(e32), .in_load(il32), .load_count(lc32)
    );

    prog_mem #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(20)) dut20 (
        .clk(clk), .rst(rst), .prog_mode(prog_mode), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_valid(v20), .fetch_data(d20),
        .fetch_err(e20), .in_load(il20), .load_count(lc20)
    );

    typedef struct packed {
        logic          e32;
        logic [IW-1:0] d32;
        logic          e20;
        logic [IW-1:0] d20;
    } rsp_t;

    rsp_t          sb[$];
    logic [IW-1:0] m32 [32];
    logic [IW-1:0] m20 [20];
    logic          m_load;
    int            cnt32, cnt20;
    logic [IW-1:0] h32, h20;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 1'b0;
        cnt32  = 0;
        cnt20  = 0;
        h32    = '0;
        h20    = '0;
        sb.delete();
    endtask

    // Apply current inputs for one clock edge, update the model, check outputs
    task automatic step();
        rsp_t r;
        logic exp_valid;
        int   fa, la;
        fa = int'(fetch_addr);
        la = int'(load_addr);
        exp_valid = fetch_req;
        if (fetch_req) begin
            r.e32 = m_load || (fa >= 32);
            r.d32 = r.e32 ? '0 : m32[fa];
            r.e20 = m_load || (fa >= 20);
            r.d20 = r.e20 ? '0 : m20[fa];
            sb.push_back(r);
        end
        if (m_load && load_we) begin
            if (la < 32) begin
                m32[la] = load_data;
                if (cnt32 < 32) cnt32++;
            end
            if (la < 20) begin
                m20[la] = load_data;
                if (cnt20 < 20) cnt20++;
            end
        end
        if (!m_load && prog_mode) begin
            m_load = 1'b1;
            cnt32  = 0;
            cnt20  = 0;
        end else if (m_load && !prog_mode) begin
            m_load = 1'b0;
        end
        @(posedge clk);
        #1;
        check("valid32", 32'(v32), 32'(exp_valid));
        check("valid20", 32'(v20), 32'(exp_valid));
        if (exp_valid) begin
            r   = sb.pop_front();
            h32 = r.d32;
            h20 = r.d20;
            check("err32", 32'(e32), 32'(r.e32));
            check("err20", 32'(e20), 32'(r.e20));
        end else begin
            check("err32_idle", 32'(e32), 32'd0);
            check("err20_idle", 32'(e20), 32'd0);
        end
        check("data32", 32'(d32), 32'(h32));
        check("data20", 32'(d20), 32'(h20));
        check("in_load32", 32'(il32), 32'(m_load));
        check("in_load20", 32'(il20), 32'(m_load));
        check("lcount32", 32'(lc32), 32'(cnt32));
        check("lcount20", 32'(lc20), 32'(cnt20));
    endtask

    task automatic fetch(input int a);
        fetch_req  = 1'b1;
        fetch_addr = AW'(a);
        step();
        fetch_req  = 1'b0;
    endtask

    task automatic write(input int a, input int d);
        load_we   = 1'b1;
        load_addr = AW'(a);
        load_data = IW'(d);
        step();
        load_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        prog_mode  = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        for (int i = 0; i < 32; i++) m32[i] = '0;
        for (int i = 0; i < 20; i++) m20[i] = '0;
        model_reset();

        // Reset state
        #1;
        check("rst_valid", 32'(v32), 32'd0);
        check("rst_err",   32'(e32), 32'd0);
        check("rst_data",  32'(d32), 32'd0);
        check("rst_inld",  32'(il32), 32'd0);
        check("rst_lcnt",  32'(lc32), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full program load, then fetch every word back-to-back
        prog_mode = 1'b1;
        step();
        for (int a = 0; a < 32; a++) write(a, a + 1);
        check("lcount32_full", 32'(lc32), 32'd32);
        check("lcount20_sat",  32'(lc20), 32'd20);
        prog_mode = 1'b0;
        step();
        fetch_req = 1'b1;
        for (int a = 0; a < 32; a++) begin
            fetch_addr = AW'(a);
            step();
        end
        fetch_req = 1'b0;
        step();

        // Out-of-range fetch on the 20-deep instance
        fetch(25);
        step();

        // Writes in RUN are ignored
        write(3, 'h3F);
        fetch(3);
        check("run_write_ignored", 32'(d32), 32'd4);

        // Fetch on the RUN->LOAD edge is serviced as RUN, next one errors
        prog_mode = 1'b1;
        fetch(7);
        check("edge_fetch_data", 32'(d32), 32'd8);
        fetch(7);
        check("load_fetch_err", 32'(e32), 32'd1);

        // Out-of-range write for DEPTH=20, then an ordinary write
        write(25, 'h2A);
        check("oor_write_lc20", 32'(lc20), 32'd0);
        write(5, 'h15);
        prog_mode = 1'b0;
        step();
        fetch(19);
        check("addr19_intact", 32'(d20), 32'd20);

        // Reset while a response is showing
        fetch(5);
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_valid", 32'(v32), 32'd0);
        check("midrst_data",  32'(d32), 32'd0);
        check("midrst_inld",  32'(il32), 32'd0);
        check("midrst_lcnt",  32'(lc20), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetch(5);
        check("post_rst_mem32", 32'(d32), 32'h15);
        check("post_rst_mem20", 32'(d20), 32'h15);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_mem.md
Name: prog_mem

Overview:
Parametrised, loadable instruction memory with a registered fetch port. It is the successor of the fixed 32x6 combinational instruction store.
- Sits between the PC/sequencer and the decoder.
- Program image is written through a load port while the block is in load mode.
- The core fetches through a req/valid port with one-cycle latency, plus out-of-range and mode-violation error reporting.

Parameters:
INSTR_W, `INSTRUCTION_WIDTH (6), instruction word width (opcode + register field)
ADDR_W, 5, address width of both ports
DEPTH, 32, implemented words; must be <= 2**ADDR_W; addresses >= DEPTH are out of range
NOP_WORD, {INSTR_W{1'b0}}, word returned on any erroneous fetch

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
prog_mode  in  1  level: 1 requests LOAD mode, 0 requests RUN mode
load_we  in  1  write strobe, honoured only in LOAD
load_addr  in  ADDR_W  write address
load_data  in  INSTR_W  write data
fetch_req  in  1  fetch request, single-cycle pulse or held
fetch_addr  in  ADDR_W  fetch address, sampled with fetch_req
fetch_valid  out  1  one-cycle pulse: fetch_data/fetch_err valid
fetch_data  out  INSTR_W  fetched word, held until next response
fetch_err  out  1  qualifies fetch_valid: address out of range or block in LOAD
in_load  out  1  1 while state == S_LOAD
load_count  out  ADDR_W+1  accepted writes since entering S_LOAD, saturating at DEPTH

Behaviour:
- Reset (asynchronous, immediate):
  - state = S_RUN
  - fetch_valid = 0, fetch_err = 0, fetch_data = NOP_WORD
  - load_count = 0, in_load = 0
  - Memory array is NOT cleared by rst; contents survive reset.
- States:
  - S_RUN -> S_LOAD on the first edge with prog_mode = 1. load_count clears to 0 on that edge.
  - S_LOAD -> S_RUN on the first edge with prog_mode = 0.
  - No other states; in_load is a registered decode of state.
- Write (S_LOAD only):
  - load_we = 1 and load_addr < DEPTH -> mem[load_addr] <= load_data at the edge; load_count++ (saturates at DEPTH).
  - load_addr >= DEPTH -> write dropped, load_count unchanged.
  - load_we in S_RUN -> ignored entirely.
  - The write on the S_RUN -> S_LOAD transition edge is ignored, because state was still S_RUN when sampled.
- Fetch (latency exactly 1):
  - fetch_req = 1 at edge N -> fetch_valid = 1 for the cycle after N.
  - S_RUN and fetch_addr < DEPTH: fetch_data = mem[fetch_addr], fetch_err = 0.
  - S_RUN and fetch_addr >= DEPTH: fetch_data = NOP_WORD, fetch_err = 1.
  - S_LOAD (state as sampled at edge N): fetch_data = NOP_WORD, fetch_err = 1.
  - Back-to-back requests give back-to-back valid pulses (throughput 1/cycle).
  - fetch_req = 0 -> fetch_valid = 0, fetch_err = 0, fetch_data holds its last value.
- Simultaneous events:
  - fetch_req on the S_RUN -> S_LOAD edge: serviced as RUN (old state).
  - fetch_req on the S_LOAD -> S_RUN edge: answered as LOAD error.
  - No read/write collision is possible, because writes and good reads are mutually exclusive by state.
- Reset mid-fetch: a pending response is lost; fetch_valid = 0 after rst.
- Width rules:
  - Addresses are compared unsigned against DEPTH.
  - load_count is ADDR_W+1 bits so DEPTH = 2**ADDR_W is representable.

Decomposition:
- Shared include OpCodes.v:
  - `INSTRUCTION_WIDTH and the NOP encoding.
  - New `PM_S_RUN / `PM_S_LOAD state encodings (1 bit).
- One sub-module, prog_mem_array: DEPTH x INSTR_W storage with one synchronous write port and one synchronous read port, no reset.
- prog_mem holds the FSM, range checks, error/NOP muxing and load_count.

Test Plan:
- Reset, prog_mode = 1, write mem[a] = a+1 for a = 0..31, prog_mode = 0, fetch 0..31 back-to-back -> fetch_valid on each following cycle, fetch_data = a+1, fetch_err = 0, load_count = 32 before exit.
- DEPTH = 20, ADDR_W = 5:
  - Fetch addr 25 in RUN -> next cycle fetch_valid = 1, fetch_err = 1, fetch_data = 6'b000000.
  - Write addr 25 in LOAD -> load_count unchanged, later fetch of addr 19 unaffected.
- In RUN, load_we = 1 to addr 3 with 6'h3F -> fetch addr 3 still returns the previously loaded word.
- Fetch addr 7 in the same cycle prog_mode rises -> valid with mem[7], err = 0. Next-cycle fetch -> err = 1, data = NOP, in_load = 1.
- Load mem[5] = 6'h15, assert rst for 1 cycle mid-fetch -> fetch_valid drops immediately, state S_RUN, load_count = 0; fetch 5 after reset returns 6'h15.
